// File: rtl/ccff_bitstream_loader.sv
// Byte-wide to serial loader for the fabric configuration flip-flop chain.
// Shifts exactly CHAIN_LEN bits MSB-first into ccff_head, qualified by shift_en.
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int CNT_W     = 16
) (
  input  logic       prog_clk,
  input  logic       pReset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       ccff_head,
  output logic       shift_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    s_idle  = 2'd0,
    s_load  = 2'd1,
    s_shift = 2'd2,
    s_done  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] chain_len_c = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] one_c       = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W+3:0] eight_c     = {{CNT_W{1'b0}}, 4'd8};

  // Bits to take from the next byte: a full byte, or whatever remains of the chain.
  function automatic logic [3:0] byte_bits(input logic [CNT_W-1:0] rem);
    logic [CNT_W+3:0] ext;
    ext = {4'b0000, rem};
    if (ext >= eight_c) begin
      return 4'd8;
    end else begin
      return ext[3:0];
    end
  endfunction

  state_t           state_r, state_next;
  logic [7:0]       sreg_r, sreg_next;
  logic [3:0]       bcnt_r, bcnt_next;
  logic [CNT_W-1:0] rem_r, rem_next;

  logic din_ready_s, ccff_head_s, shift_en_s, busy_s, done_s;

  // State and datapath registers.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_r <= s_idle;
      sreg_r  <= 8'h00;
      bcnt_r  <= 4'd0;
      rem_r   <= '0;
    end else begin
      state_r <= state_next;
      sreg_r  <= sreg_next;
      bcnt_r  <= bcnt_next;
      rem_r   <= rem_next;
    end
  end

  // Next-state and datapath update; abort outranks start and the handshake.
  always_comb begin
    state_next = state_r;
    sreg_next  = sreg_r;
    bcnt_next  = bcnt_r;
    rem_next   = rem_r;
    if (abort) begin
      state_next = s_idle;
      bcnt_next  = 4'd0;
      rem_next   = '0;
    end else begin
      case (state_r)
        s_idle, s_done: begin
          if (start) begin
            state_next = s_load;
            rem_next   = chain_len_c;
          end else begin
            state_next = state_r;
          end
        end
        s_load: begin
          if (din_valid) begin
            state_next = s_shift;
            sreg_next  = din;
            bcnt_next  = byte_bits(rem_r);
          end else begin
            state_next = s_load;
          end
        end
        s_shift: begin
          sreg_next = {sreg_r[6:0], 1'b0};
          bcnt_next = bcnt_r - 4'd1;
          rem_next  = rem_r - one_c;
          if (bcnt_r == 4'd1) begin
            state_next = (rem_r == one_c) ? s_done : s_load;
          end else begin
            state_next = s_shift;
          end
        end
        default: begin
          state_next = s_idle;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the outputs can be registered
  // without adding a cycle of latency.
  always_comb begin
    din_ready_s = 1'b0;
    ccff_head_s = 1'b0;
    shift_en_s  = 1'b0;
    busy_s      = 1'b0;
    done_s      = 1'b0;
    case (state_next)
      s_load: begin
        din_ready_s = 1'b1;
        busy_s      = 1'b1;
      end
      s_shift: begin
        shift_en_s  = 1'b1;
        ccff_head_s = sreg_next[7];
        busy_s      = 1'b1;
      end
      s_done: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Output registers; reset drops every output at once, halting the chain.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      din_ready <= 1'b0;
      ccff_head <= 1'b0;
      shift_en  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      din_ready <= din_ready_s;
      ccff_head <= ccff_head_s;
      shift_en  <= shift_en_s;
      busy      <= busy_s;
      done      <= done_s;
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader with CHAIN_LEN = 16, 12 and 1.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_v  [3];
  logic       start_v [3];
  logic       abort_v [3];
  logic       valid_v [3];
  logic [7:0] din_v   [3];
  logic       ready_v [3];
  logic       shen_v  [3];
  logic       head_v  [3];
  logic       busy_v  [3];
  logic       done_v  [3];

  int checks = 0;
  int passes = 0;

  ccff_bitstream_loader #(.CHAIN_LEN(16), .CNT_W(16)) dut16 (
    .prog_clk(clk), .pReset_n(rstn_v[0]), .start(start_v[0]), .abort(abort_v[0]),
    .din(din_v[0]), .din_valid(valid_v[0]), .din_ready(ready_v[0]), .ccff_head(head_v[0]),
    .shift_en(shen_v[0]), .busy(busy_v[0]), .done(done_v[0]));

  ccff_bitstream_loader #(.CHAIN_LEN(12), .CNT_W(8)) dut12 (
    .prog_clk(clk), .pReset_n(rstn_v[1]), .start(start_v[1]), .abort(abort_v[1]),
    .din(din_v[1]), .din_valid(valid_v[1]), .din_ready(ready_v[1]), .ccff_head(head_v[1]),
    .shift_en(shen_v[1]), .busy(busy_v[1]), .done(done_v[1]));

  ccff_bitstream_loader #(.CHAIN_LEN(1), .CNT_W(4)) dut1 (
    .prog_clk(clk), .pReset_n(rstn_v[2]), .start(start_v[2]), .abort(abort_v[2]),
    .din(din_v[2]), .din_valid(valid_v[2]), .din_ready(ready_v[2]), .ccff_head(head_v[2]),
    .shift_en(shen_v[2]), .busy(busy_v[2]), .done(done_v[2]));

  // One cycle of stimulus with the outputs expected after the following edge.
  typedef struct packed {
    logic       st;
    logic [7:0] din;
    logic       vld;
    logic [4:0] exp;   // {din_ready, shift_en, ccff_head, busy, done}
  } vec_t;

  vec_t tbl [20];

  function automatic logic [4:0] obs(input int d);
    return {ready_v[d], shen_v[d], head_v[d], busy_v[d], done_v[d]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one load: start pulse, bytes fed with din_valid high (optionally a gap
  // before byte 2), optional abort (kind 1) or start (kind 2) poked at shift #poke_at.
  task automatic load(input int d, input logic [31:0] bytes, input int nbytes,
                      input int gap, input int poke_at, input int poke_kind,
                      output logic [31:0] bits, output int nsh, output int ncyc,
                      output int bad);
    int bidx = 0;
    int g = gap;
    logic ingap = 1'b0;
    logic [4:0] o;
    bits = 32'h0; nsh = 0; ncyc = 0; bad = 0;
    @(negedge clk);
    start_v[d] = 1'b1; valid_v[d] = 1'b0;
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      o = obs(d);
      if (ingap && (o != 5'b10010)) bad++;
      ingap = 1'b0;
      if (o[4] && o[3]) bad++;
      if (o[0]) begin
        ncyc = c;
        break;
      end
      if (o[3]) begin
        bits = {bits[30:0], o[2]};
        nsh++;
      end
      if (poke_at != 0 && o[3] && nsh == poke_at) begin
        if (poke_kind == 1) abort_v[d] = 1'b1;
        else start_v[d] = 1'b1;
      end
      if (o[4] && bidx == 1 && g > 0) begin
        valid_v[d] = 1'b0;
        g--;
        ingap = 1'b1;
      end else if (bidx < nbytes) begin
        valid_v[d] = 1'b1;
        din_v[d] = bytes[31-8*bidx -: 8];
        if (o[4]) bidx++;
      end else begin
        valid_v[d] = 1'b0;
      end
      @(negedge clk);
      start_v[d] = 1'b0;
      if (abort_v[d]) begin
        abort_v[d] = 1'b0;
        break;
      end
    end
    valid_v[d] = 1'b0;
  endtask

  logic [31:0] bits;
  int nsh, ncyc, bad;

  initial begin
    tbl[0]  = {1'b1, 8'hA5, 1'b1, 5'b10010};
    tbl[1]  = {1'b0, 8'hA5, 1'b1, 5'b01110};
    tbl[2]  = {1'b0, 8'h3C, 1'b1, 5'b01010};
    tbl[3]  = {1'b0, 8'h3C, 1'b1, 5'b01110};
    tbl[4]  = {1'b0, 8'h3C, 1'b1, 5'b01010};
    tbl[5]  = {1'b0, 8'h3C, 1'b1, 5'b01010};
    tbl[6]  = {1'b0, 8'h3C, 1'b1, 5'b01110};
    tbl[7]  = {1'b0, 8'h3C, 1'b1, 5'b01010};
    tbl[8]  = {1'b0, 8'h3C, 1'b1, 5'b01110};
    tbl[9]  = {1'b0, 8'h3C, 1'b1, 5'b10010};
    tbl[10] = {1'b0, 8'h3C, 1'b1, 5'b01010};
    tbl[11] = {1'b0, 8'h3C, 1'b1, 5'b01010};
    tbl[12] = {1'b0, 8'h3C, 1'b1, 5'b01110};
    tbl[13] = {1'b0, 8'h3C, 1'b1, 5'b01110};
    tbl[14] = {1'b0, 8'h3C, 1'b1, 5'b01110};
    tbl[15] = {1'b0, 8'h3C, 1'b1, 5'b01110};
    tbl[16] = {1'b0, 8'h3C, 1'b1, 5'b01010};
    tbl[17] = {1'b0, 8'h3C, 1'b1, 5'b01010};
    tbl[18] = {1'b0, 8'hFF, 1'b1, 5'b00001};
    tbl[19] = {1'b0, 8'hFF, 1'b1, 5'b00001};

    for (int d = 0; d < 3; d++) begin
      rstn_v[d] = 1'b0; start_v[d] = 1'b0; abort_v[d] = 1'b0;
      valid_v[d] = 1'b0; din_v[d] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("reset_outputs_%0d", d), obs(d), 5'b00000);
    for (int d = 0; d < 3; d++) rstn_v[d] = 1'b1;
    repeat (2) @(negedge clk);

    // Cycle-exact 16-bit load, then an extra byte refused in DONE.
    for (int i = 0; i < 20; i++) begin
      start_v[0] = tbl[i].st;
      din_v[0]   = tbl[i].din;
      valid_v[0] = tbl[i].vld;
      @(negedge clk);
      chk($sformatf("vec%0d", i), obs(0), tbl[i].exp);
    end
    start_v[0] = 1'b0;
    valid_v[0] = 1'b0;

    // Backpressure: five idle cycles before byte 2, same bitstream.
    load(0, 32'hA53C0000, 2, 5, 0, 0, bits, nsh, ncyc, bad);
    chk("gap_bits", bits, 32'hA53C);
    chk("gap_nshift", nsh, 16);
    chk("gap_cycles", ncyc, 24);
    chk("gap_hold", bad, 0);

    // Abort during the 4th shift cycle of byte 2, then a full reload.
    load(0, 32'hA53C0000, 2, 0, 12, 1, bits, nsh, ncyc, bad);
    chk("abort_nshift", nsh, 12);
    chk("abort_next", obs(0), 5'b00000);
    repeat (2) @(negedge clk);
    chk("abort_idle", obs(0), 5'b00000);
    load(0, 32'h5AC30000, 2, 0, 0, 0, bits, nsh, ncyc, bad);
    chk("reload_bits", bits, 32'h5AC3);
    chk("reload_nshift", nsh, 16);
    chk("reload_cycles", ncyc, 19);
    chk("reload_no_ready_in_shift", bad, 0);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; din_v[0] = 8'hA5; valid_v[0] = 1'b1;
    for (int c = 0; c < 20 && !shen_v[0]; c++) @(negedge clk);
    @(negedge clk);
    chk("rst_pre_shift", shen_v[0], 1'b1);
    #2;
    rstn_v[0] = 1'b0;
    #1;
    chk("rst_immediate", obs(0), 5'b00000);
    @(negedge clk);
    rstn_v[0] = 1'b1;
    valid_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_idle", obs(0), 5'b00000);

    // start pulsed mid-shift must not restart the load.
    load(0, 32'hA53C0000, 2, 0, 5, 2, bits, nsh, ncyc, bad);
    chk("restart_ignored_bits", bits, 32'hA53C);
    chk("restart_ignored_nshift", nsh, 16);
    chk("restart_ignored_cycles", ncyc, 19);

    // 12-bit chain: low nibble of the last byte discarded.
    load(1, 32'hA53C0000, 2, 0, 0, 0, bits, nsh, ncyc, bad);
    chk("c12_bits", bits, 32'hA53);
    chk("c12_nshift", nsh, 12);
    chk("c12_cycles", ncyc, 15);
    chk("c12_no_ready_in_shift", bad, 0);
    valid_v[1] = 1'b1; din_v[1] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("c12_extra_byte_%0d", i), {ready_v[1], shen_v[1], busy_v[1], done_v[1]}, 4'b0001);
    end
    valid_v[1] = 1'b0;

    // Single-bit chain.
    load(2, 32'h80000000, 1, 0, 0, 0, bits, nsh, ncyc, bad);
    chk("c1_bits", bits, 32'h1);
    chk("c1_nshift", nsh, 1);
    chk("c1_cycles", ncyc, 3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Serializes a byte-wide configuration bitstream into the single-bit configuration chain (ccff) of the fabric. It sits directly upstream of the configuration flip-flop chain. The chain's outputs drive the routing and LUT configuration through the direct interconnect wires. The block accepts bytes over a valid/ready handshake, shifts exactly CHAIN_LEN bits MSB-first into `ccff_head` with a qualifying shift enable, and flags completion.

## Interface

Parameters:
- `CHAIN_LEN`, default 1024: total configuration bits in the chain; must be ≥ 1.
- `CNT_W`, default 16: width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- `prog_clk` input 1: programming clock; all state is on its rising edge.
- `pReset_n` input 1: asynchronous, active-low reset. It is released synchronously by the system.
- `start` input 1: single-cycle pulse that begins a load. It is sampled only in IDLE or DONE.
- `abort` input 1: synchronous abort. It returns the block to IDLE from any state.
- `din` input 8: bitstream byte; bit 7 is shifted first.
- `din_valid` input 1: `din` is valid.
- `din_ready` output 1: the block accepts `din` this cycle.
- `ccff_head` output 1: serial data into the head of the configuration chain.
- `shift_en` output 1: the chain must shift on this `prog_clk` edge; `ccff_head` is valid whenever this is high.
- `busy` output 1: a load is in progress (LOAD or SHIFT).
- `done` output 1: all CHAIN_LEN bits have been shifted; held high until the next `start`, `abort` or reset.

## Operation

- Internal state:
  - FSM with states IDLE, LOAD, SHIFT and DONE.
  - 8-bit shift register `sreg`.
  - 4-bit in-byte counter `bcnt`.
  - CNT_W-bit remaining-bit counter `rem`.
- IDLE:
  - All outputs are 0.
  - `start` → LOAD and `rem` ← CHAIN_LEN.
- LOAD:
  - `din_ready` = 1 and `busy` = 1.
  - On `din_valid & din_ready`: `sreg` ← `din`; `bcnt` ← min(8, `rem`); → SHIFT.
  - With no valid byte, the block waits indefinitely in LOAD.
- SHIFT:
  - `shift_en` = 1, `ccff_head` = `sreg[7]` and `busy` = 1.
  - Each cycle: `sreg` ← `sreg` << 1, `bcnt` ← `bcnt` − 1, `rem` ← `rem` − 1.
  - When `bcnt` = 1: if `rem` = 1 → DONE, otherwise → LOAD.
- Final partial byte: when CHAIN_LEN is not a multiple of 8, only the top `rem` bits of the last byte are shifted. The low bits are discarded.
- DONE:
  - `done` = 1; `din_ready`, `busy` and `shift_en` are 0.
  - `start` → LOAD and clears `done` (reload).
- `abort` in any state → IDLE next cycle. It clears `rem`, `bcnt` and `done`. `abort` has priority over `start` and over the handshake.
- `start` while in LOAD or SHIFT is ignored.
- Extra bytes offered after DONE are not accepted (`din_ready` = 0).

## Timing

- Reset values (asynchronous, immediate on `pReset_n` = 0):
  - FSM = IDLE; `sreg`, `bcnt` and `rem` = 0.
  - Outputs `din_ready`, `ccff_head`, `shift_en`, `busy` and `done` = 0.
- Reset mid-load aborts with no further `shift_en` pulses. A partially loaded chain is left as is.
- All outputs are decoded from registered state with no combinational path from inputs. Exception: none; `din_ready` depends on state only.
- `start` accepted at edge N → `din_ready` = 1 from cycle N+1.
- Byte accepted at edge M → `shift_en` high for cycles M+1 … M+k, where k = min(8, `rem`).
  - Non-final byte: `din_ready` high again in cycle M+9.
  - Throughput: 9 cycles per full byte with `din_valid` held high.
- `done` rises in the cycle after the last `shift_en` cycle.
- Total load time with data always valid: 1 + 9·⌈CHAIN_LEN/8⌉ − (8·⌈CHAIN_LEN/8⌉ − CHAIN_LEN) cycles from `start` to `done`.

## Test plan

- CHAIN_LEN = 16; `start`, then bytes 0xA5 and 0x3C with `din_valid` always high:
  - `ccff_head` on the 16 `shift_en` cycles = 1010 0101 0011 1100.
  - `done` = 1 exactly 19 cycles after the `start` edge.
  - `din_ready` is never high in SHIFT.
- CHAIN_LEN = 12; bytes 0xA5 and 0x3C:
  - 12 shift cycles with data 1010 0101 0011.
  - The low nibble 0xC is never shifted.
  - `done` = 1; a third valid byte stays unaccepted.
- Backpressure: `din_valid` low for 5 cycles between bytes. The block stays in LOAD, `shift_en` = 0, `busy` = 1, and the bitstream is unchanged versus the no-gap run.
- `abort` during the 4th shift cycle of byte 2:
  - Next cycle: `shift_en`, `busy` and `done` are 0 and FSM = IDLE.
  - A new `start` restarts with `rem` = CHAIN_LEN; a full reload completes correctly.
- `pReset_n` pulsed low mid-SHIFT: all outputs go to 0 immediately. After release, the block idles until `start`, and `start` while busy is ignored.
- CHAIN_LEN = 1; byte 0x80: exactly one `shift_en` cycle with `ccff_head` = 1, then `done` = 1.
